// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase-generation stage.
//
// Purpose:
//   Holds the phase/select widths, the waveform select encoding used by the
//   8:1 waveform mux and by register-map code, and the state type of the
//   deferred-select FSM inside dds_phase_ctrl.
//
// Contents:
//   PHASE_W      width of the phase address fed to every waveform generator
//   WAVE_SEL_W   width of the waveform select
//   wave_sel_e   waveform select encoding, WAVE_0..WAVE_7 = 3'd0..3'd7
//   sel_state_e  deferred-select FSM states
//   phaseTop()   extracts the top PHASE_W bits of an accumulator value
package dds_pkg;

    localparam int PHASE_W    = 8;
    localparam int WAVE_SEL_W = 3;

    typedef enum logic [WAVE_SEL_W-1:0] {
        WAVE_0 = 3'd0,
        WAVE_1 = 3'd1,
        WAVE_2 = 3'd2,
        WAVE_3 = 3'd3,
        WAVE_4 = 3'd4,
        WAVE_5 = 3'd5,
        WAVE_6 = 3'd6,
        WAVE_7 = 3'd7
    } wave_sel_e;

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_e;

    // The phase address is always the most significant PHASE_W bits of the
    // accumulator, independent of how wide the accumulator is.
    function automatic logic [PHASE_W-1:0] phaseTop(input logic [31:0] accVal,
                                                     input int unsigned accWidth);
        logic [31:0] shifted;
        shifted  = accVal >> (accWidth - PHASE_W);
        phaseTop = shifted[PHASE_W-1:0];
    endfunction

endpackage : dds_pkg

// File: rtl/dds_phase_ctrl.sv
// DDS phase accumulator and glitch-free waveform select control.
//
// Purpose:
//   Runs the phase accumulator, produces the 8b phase address for the
//   waveform generators and the 3b waveform select for the 8:1 mux. Tuning
//   word and waveform select changes are held back until the accumulator
//   wraps, so the mux output only switches on a period boundary.
//
// Parameters:
//   ACC_WIDTH      accumulator width in bits, must be larger than PHASE_W
//   FTW_SYNC_WRAP  1: new tuning word takes effect at the next wrap
//                  0: new tuning word takes effect on the next clock edge
//
// Ports:
//   clk_i            system clock, all state on the rising edge
//   rst_i            synchronous reset, active-high
//   en_i             accumulate enable
//   ftw_i            frequency tuning word
//   ftw_valid_i      tuning word handshake valid
//   ftw_ready_o      tuning word handshake ready
//   poff_i           phase offset, added to the phase output mod 256
//   sel_req_i        requested waveform select
//   sel_req_valid_i  select request strobe, never back-pressured
//   phase_o          registered phase address
//   sel_o            registered waveform select
//   wrap_o           one-cycle pulse on the first sample of a new period
//   sel_pending_o    a select change is queued
module dds_phase_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_WIDTH     = 24,
    parameter bit FTW_SYNC_WRAP = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [ACC_WIDTH-1:0]  ftw_i,
    input  logic                  ftw_valid_i,
    output logic                  ftw_ready_o,
    input  logic [PHASE_W-1:0]    poff_i,
    input  logic [WAVE_SEL_W-1:0] sel_req_i,
    input  logic                  sel_req_valid_i,
    output logic [PHASE_W-1:0]    phase_o,
    output logic [WAVE_SEL_W-1:0] sel_o,
    output logic                  wrap_o,
    output logic                  sel_pending_o
);

    // Accumulator and phase output state
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 wrap_q, wrap_d;

    // Tuning word state: active word plus a one-entry shadow register
    logic [ACC_WIDTH-1:0] ftwAct_q, ftwAct_d;
    logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
    logic                 shadowFull_q, shadowFull_d;

    // Waveform select state
    sel_state_e           selState_q, selState_d;
    wave_sel_e            pendVal_q, pendVal_d;
    wave_sel_e            sel_q, sel_d;

    // Combinational helpers
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 wrapEvent;
    logic                 idle;
    logic                 ftwXfer;
    logic [PHASE_W-1:0]   phaseNext;
    wave_sel_e            selReq;

    // The sum is one bit wider than the accumulator so the top bit is the
    // carry that marks the end of a period. A wrap only counts when the
    // accumulator actually steps. With the accumulator stopped or a zero
    // tuning word no wrap can ever happen, so queued changes are applied
    // immediately instead of waiting forever.
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, ftwAct_q};
        carry     = sum[ACC_WIDTH];
        wrapEvent = en_i & carry;
        idle      = ~en_i | (ftwAct_q == '0);
        phaseNext = phaseTop(32'(sum[ACC_WIDTH-1:0]), ACC_WIDTH) + poff_i;
        selReq    = wave_sel_e'(sel_req_i);
        ftwXfer   = ftw_valid_i & ftw_ready_o;
    end

    // In deferred mode the shadow register is the only buffer, so the
    // interface is ready exactly when the shadow is empty. In immediate mode
    // the word goes straight into the active register and is always ready.
    assign ftw_ready_o = FTW_SYNC_WRAP ? ~shadowFull_q : 1'b1;

    // Accumulator step. When disabled the accumulator and phase hold, and the
    // wrap pulse is cleared so it stays exactly one cycle wide.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (en_i) begin
            acc_d   = sum[ACC_WIDTH-1:0];
            phase_d = phaseNext;
            wrap_d  = carry;
        end
    end

    // Tuning word path. A shadow that is full can never accept a new word,
    // so the load-from-shadow and capture-into-shadow cases are exclusive.
    // The word loaded at a wrap is used from the following step onward.
    always_comb begin
        ftwAct_d     = ftwAct_q;
        shadow_d     = shadow_q;
        shadowFull_d = shadowFull_q;
        if (FTW_SYNC_WRAP) begin
            if (shadowFull_q && (wrapEvent || idle)) begin
                ftwAct_d     = shadow_q;
                shadowFull_d = 1'b0;
            end
            if (ftwXfer) begin
                shadow_d     = ftw_i;
                shadowFull_d = 1'b1;
            end
        end else begin
            if (ftwXfer) begin
                ftwAct_d = ftw_i;
            end
        end
    end

    // Deferred select FSM. A request that arrives in the carry cycle is
    // applied at that same wrap rather than waiting a whole extra period;
    // a request that arrives while one is already pending replaces it.
    always_comb begin
        selState_d = selState_q;
        pendVal_d  = pendVal_q;
        sel_d      = sel_q;
        unique case (selState_q)
            SEL_IDLE: begin
                if (sel_req_valid_i) begin
                    if (wrapEvent) begin
                        sel_d = selReq;
                    end else begin
                        selState_d = SEL_PEND;
                        pendVal_d  = selReq;
                    end
                end
            end
            SEL_PEND: begin
                if (sel_req_valid_i) begin
                    if (wrapEvent) begin
                        sel_d      = selReq;
                        selState_d = SEL_IDLE;
                    end else begin
                        pendVal_d = selReq;
                    end
                end else if (wrapEvent || idle) begin
                    sel_d      = pendVal_q;
                    selState_d = SEL_IDLE;
                end
            end
            default: begin
                selState_d = SEL_IDLE;
            end
        endcase
    end

    // State registers. Reset discards any queued select and any word waiting
    // in the shadow register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q        <= '0;
            phase_q      <= '0;
            wrap_q       <= 1'b0;
            ftwAct_q     <= '0;
            shadow_q     <= '0;
            shadowFull_q <= 1'b0;
            selState_q   <= SEL_IDLE;
            pendVal_q    <= WAVE_0;
            sel_q        <= WAVE_0;
        end else begin
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            wrap_q       <= wrap_d;
            ftwAct_q     <= ftwAct_d;
            shadow_q     <= shadow_d;
            shadowFull_q <= shadowFull_d;
            selState_q   <= selState_d;
            pendVal_q    <= pendVal_d;
            sel_q        <= sel_d;
        end
    end

    // Registered outputs
    assign phase_o       = phase_q;
    assign wrap_o        = wrap_q;
    assign sel_o         = sel_q;
    assign sel_pending_o = (selState_q == SEL_PEND);

endmodule : dds_phase_ctrl

// File: tb/tb_dds_phase_ctrl.sv
// Directed testbench for dds_phase_ctrl with a 24-bit accumulator and
// tuning word changes deferred to the wrap.
module tb_dds_phase_ctrl;
    import dds_pkg::*;

    localparam int ACC_WIDTH = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [ACC_WIDTH-1:0]  ftw;
    logic                  ftwValid;
    logic                  ftwReady;
    logic [PHASE_W-1:0]    poff;
    logic [WAVE_SEL_W-1:0] selReq;
    logic                  selReqValid;
    logic [PHASE_W-1:0]    phase;
    logic [WAVE_SEL_W-1:0] sel;
    logic                  wrap;
    logic                  selPending;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    dds_phase_ctrl #(
        .ACC_WIDTH     (ACC_WIDTH),
        .FTW_SYNC_WRAP (1'b1)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .ftw_i           (ftw),
        .ftw_valid_i     (ftwValid),
        .ftw_ready_o     (ftwReady),
        .poff_i          (poff),
        .sel_req_i       (selReq),
        .sel_req_valid_i (selReqValid),
        .phase_o         (phase),
        .sel_o           (sel),
        .wrap_o          (wrap),
        .sel_pending_o   (selPending)
    );

    // Drive all data inputs in one go, just after an edge
    task automatic applyStimulus(input logic                  enV,
                                 input logic [ACC_WIDTH-1:0]  ftwV,
                                 input logic                  ftwValidV,
                                 input logic [PHASE_W-1:0]    poffV,
                                 input logic [WAVE_SEL_W-1:0] selV,
                                 input logic                  selValidV);
        en          = enV;
        ftw         = ftwV;
        ftwValid    = ftwValidV;
        poff        = poffV;
        selReq      = selV;
        selReqValid = selValidV;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock and check the phase/wrap sample it produced
    task automatic stepCheck(input string tag, input int expPhase, input logic expWrap);
        tick();
        checkOutput({tag, " phase"}, 32'(phase), expPhase);
        checkOutput({tag, " wrap"}, 32'(wrap), 32'(expWrap));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " phase"}, 32'(phase), 32'h00);
        checkOutput({tag, " sel"}, 32'(sel), 32'd0);
        checkOutput({tag, " wrap"}, 32'(wrap), 32'd0);
        checkOutput({tag, " ftw_ready"}, 32'(ftwReady), 32'd1);
        checkOutput({tag, " sel_pending"}, 32'(selPending), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        checkResetState("reset");

        // Idle rule: tuning word and select offered with en=0 and ftw_act=0
        rst = 1'b0;
        applyStimulus(1'b0, 24'h080000, 1'b1, 8'h00, 3'd4, 1'b1);
        tick();
        checkOutput("idle xfer ftw_ready", 32'(ftwReady), 32'd0);
        checkOutput("idle xfer sel_pending", 32'(selPending), 32'd1);
        checkOutput("idle xfer sel", 32'(sel), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        checkOutput("idle load ftw_ready", 32'(ftwReady), 32'd1);
        checkOutput("idle load sel", 32'(sel), 32'd4);
        checkOutput("idle load sel_pending", 32'(selPending), 32'd0);
        checkOutput("idle load phase", 32'(phase), 32'h00);
        checkOutput("idle load wrap", 32'(wrap), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        stepCheck("idle run1", 8'h08, 1'b0);
        stepCheck("idle run2", 8'h10, 1'b0);

        // Maximum tuning word: carries on every step except the first
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 24'hFFFFFF, 1'b1, 8'h00, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        stepCheck("maxftw s1", 8'hFF, 1'b0);
        stepCheck("maxftw s2", 8'hFF, 1'b1);
        stepCheck("maxftw s3", 8'hFF, 1'b1);

        // Steady accumulation with ftw=0x100000
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 24'h100000, 1'b1, 8'h00, 3'd0, 1'b0);
        tick();
        checkOutput("steady xfer phase", 32'(phase), 32'h00);
        checkOutput("steady xfer ftw_ready", 32'(ftwReady), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        checkOutput("steady load phase", 32'(phase), 32'h00);
        checkOutput("steady load ftw_ready", 32'(ftwReady), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            stepCheck("steady", (i * 16) % 256, i == 16);
        end

        // Deferred select: request 5 mid-period
        for (int j = 1; j <= 5; j++) begin
            stepCheck("defer", j * 16, 1'b0);
        end
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd5, 1'b1);
        stepCheck("defer req", 8'h60, 1'b0);
        checkOutput("defer req sel_pending", 32'(selPending), 32'd1);
        checkOutput("defer req sel", 32'(sel), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int j = 7; j <= 15; j++) begin
            stepCheck("defer", j * 16, 1'b0);
        end
        checkOutput("defer hold sel", 32'(sel), 32'd0);
        checkOutput("defer hold sel_pending", 32'(selPending), 32'd1);
        stepCheck("defer wrap", 8'h00, 1'b1);
        checkOutput("defer wrap sel", 32'(sel), 32'd5);
        checkOutput("defer wrap sel_pending", 32'(selPending), 32'd0);

        // Overwrite: requests 2 then 6 within one period, last one wins
        for (int k = 1; k <= 3; k++) begin
            stepCheck("ovr", k * 16, 1'b0);
        end
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd2, 1'b1);
        stepCheck("ovr req2", 8'h40, 1'b0);
        checkOutput("ovr req2 sel_pending", 32'(selPending), 32'd1);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int k = 5; k <= 7; k++) begin
            stepCheck("ovr", k * 16, 1'b0);
        end
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd6, 1'b1);
        stepCheck("ovr req6", 8'h80, 1'b0);
        checkOutput("ovr req6 sel_pending", 32'(selPending), 32'd1);
        checkOutput("ovr req6 sel", 32'(sel), 32'd5);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int k = 9; k <= 15; k++) begin
            stepCheck("ovr", k * 16, 1'b0);
        end
        stepCheck("ovr wrap", 8'h00, 1'b1);
        checkOutput("ovr wrap sel", 32'(sel), 32'd6);
        checkOutput("ovr wrap sel_pending", 32'(selPending), 32'd0);

        // Collision: request 3 in the exact carry cycle
        for (int m = 1; m <= 15; m++) begin
            stepCheck("coll", m * 16, 1'b0);
        end
        checkOutput("coll pre sel_pending", 32'(selPending), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd3, 1'b1);
        stepCheck("coll wrap", 8'h00, 1'b1);
        checkOutput("coll wrap sel", 32'(sel), 32'd3);
        checkOutput("coll wrap sel_pending", 32'(selPending), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);

        // Deferred tuning word: 0x200000 offered mid-period
        for (int n = 1; n <= 4; n++) begin
            stepCheck("ftw", n * 16, 1'b0);
        end
        applyStimulus(1'b1, 24'h200000, 1'b1, 8'h00, 3'd0, 1'b0);
        stepCheck("ftw xfer", 8'h50, 1'b0);
        checkOutput("ftw xfer ftw_ready", 32'(ftwReady), 32'd0);
        applyStimulus(1'b1, 24'h300000, 1'b1, 8'h00, 3'd0, 1'b0);
        for (int n = 6; n <= 15; n++) begin
            stepCheck("ftw blocked", n * 16, 1'b0);
        end
        checkOutput("ftw blocked ftw_ready", 32'(ftwReady), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        stepCheck("ftw wrap", 8'h00, 1'b1);
        checkOutput("ftw wrap ftw_ready", 32'(ftwReady), 32'd1);
        for (int p = 1; p <= 8; p++) begin
            stepCheck("ftw new", (p * 32) % 256, p == 8);
        end
        stepCheck("ftw no second load", 8'h20, 1'b0);

        // Phase offset 0x40 applied to a running phase
        applyStimulus(1'b1, '0, 1'b0, 8'h40, 3'd0, 1'b0);
        stepCheck("poff a", 8'h80, 1'b0);
        stepCheck("poff b", 8'hA0, 1'b0);
        stepCheck("poff c", 8'hC0, 1'b0);
        stepCheck("poff d", 8'hE0, 1'b0);
        stepCheck("poff roll", 8'h00, 1'b0);
        stepCheck("poff e", 8'h20, 1'b0);
        stepCheck("poff wrap", 8'h40, 1'b1);

        // Reset while a select is pending and the shadow is full
        applyStimulus(1'b1, 24'h111111, 1'b1, 8'h40, 3'd7, 1'b1);
        stepCheck("midrst pre", 8'h60, 1'b0);
        checkOutput("midrst pre sel_pending", 32'(selPending), 32'd1);
        checkOutput("midrst pre ftw_ready", 32'(ftwReady), 32'd0);
        applyStimulus(1'b1, '0, 1'b0, 8'h40, 3'd0, 1'b0);
        rst = 1'b1;
        tick();
        checkResetState("midrst");
        rst = 1'b0;
        applyStimulus(1'b1, '0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        checkOutput("postrst phase", 32'(phase), 32'h00);
        checkOutput("postrst sel", 32'(sel), 32'd0);
        checkOutput("postrst wrap", 32'(wrap), 32'd0);
        checkOutput("postrst sel_pending", 32'(selPending), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_dds_phase_ctrl

// File: doc/dds_phase_ctrl.md
Name: dds_phase_ctrl

Overview:
Phase-generation stage directly upstream of the 8:1 waveform select mux. It runs the DDS phase accumulator, produces the 8b phase address that drives every waveform generator, and produces the 3b waveform select. Tuning-word and waveform-select changes are deferred to the accumulator wrap, so the mux output switches only at a period boundary and never glitches mid-cycle.

Parameters:
ACC_WIDTH, 24, phase accumulator width in bits (must be > PHASE_W)
FTW_SYNC_WRAP, 1, 1 = a new tuning word takes effect at the next wrap; 0 = it takes effect on the next clock edge

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  accumulate enable
ftw  input  ACC_WIDTH  frequency tuning word
ftw_valid  input  1  ftw handshake valid
ftw_ready  output  1  ftw handshake ready
poff  input  8  phase offset, added to phase output mod 256
sel_req  input  3  requested waveform select
sel_req_valid  input  1  sel_req strobe (no backpressure)
phase  output  8  phase address to waveform generators
sel  output  3  waveform select to the mux
wrap  output  1  one-cycle pulse on the first sample of a new period
sel_pending  output  1  a select change is queued

Behaviour:
- Clocking and reset: all state is on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: acc=0, ftw_act=0, shadow empty, phase=0, sel=0, wrap=0, ftw_ready=1, sel_pending=0.
- Per-edge step with en=1:
  - sum = acc + ftw_act, computed ACC_WIDTH+1 wide; carry = sum[ACC_WIDTH].
  - acc <= sum[ACC_WIDTH-1:0].
  - phase <= sum[ACC_WIDTH-1 -: 8] + poff, mod 256.
  - wrap <= carry.
- Latency: all outputs are registered, one-cycle latency. phase, wrap and any sel change update on the same edge, so a new sel is aligned with the first sample of the new period.
- en=0:
  - acc and phase hold; wrap <= 0.
  - Handshakes are still accepted.
  - The idle rule below applies.
- FTW path, FTW_SYNC_WRAP=1:
  - Transfer occurs when ftw_valid && ftw_ready; ftw is captured into the shadow, the shadow becomes full, and ftw_ready <= 0.
  - On an en=1 edge with carry and the shadow full: ftw_act <= shadow, the shadow empties, and ftw_ready <= 1 on that edge. The new ftw_act first applies on the following step.
- FTW path, FTW_SYNC_WRAP=0: ftw_ready is constantly 1, and each transfer loads ftw_act on the next edge.
- Select path, FSM SEL_IDLE / SEL_PEND:
  - SEL_IDLE + sel_req_valid -> SEL_PEND; pend_val <= sel_req; sel_pending <= 1.
  - SEL_PEND + sel_req_valid -> stay in SEL_PEND; pend_val is overwritten (last request wins).
  - SEL_PEND + en=1 + carry -> sel <= pend_val; go to SEL_IDLE; sel_pending <= 0.
  - sel_req_valid in the same cycle as a carry: sel_req is applied at that wrap (sel <= sel_req) and the FSM goes to SEL_IDLE.
  - A request equal to the current sel still queues and completes normally.
- Idle rule (no-deadlock): when en=0 or ftw_act==0, no wrap can occur. In that case:
  - A full shadow loads ftw_act on the next edge.
  - A pending sel is applied on the next edge.
- Wrap-around: acc wraps mod 2^ACC_WIDTH. ftw = 2^ACC_WIDTH-1 is legal and carries on every step except the first from acc=0.
- poff: changes take effect on the next phase update with no deferral. A poff change alone never asserts wrap.
- Reset mid-operation: a pending sel and a full shadow are discarded; all values return to reset values.

Decomposition:
- Shared package dds_pkg holds:
  - PHASE_W=8 and WAVE_SEL_W=3.
  - The waveform select enum (WAVE_0..WAVE_7 encodings 3'd0..3'd7), shared with the mux and with register-map code.
  - The sel FSM state typedef.
- No sub-module: the accumulator, shadow register and select FSM live in one module.

Test Plan:
- Steady accumulation. Stimulus: rst, then ftw=0x100000 accepted, en=1, poff=0. Response: after the load, phase steps 0x00,0x10,...,0xF0,0x00; wrap is high only with the 0x00 sample, every 16 cycles.
- Deferred select change. Stimulus: same run, sel_req=3'd5 pulsed mid-period. Response: sel_pending=1 immediately; sel holds 0 until the wrap edge; sel=5 coincides with wrap=1 and phase=0x00; sel_pending clears on that edge.
- Request overwrite and same-cycle collision. Stimulus: sel_req 2 then 6 within one period, then sel_req=3 in the exact carry cycle. Response: sel goes to 6 at the first wrap; sel=3 is applied at the colliding wrap with no extra pending period.
- FTW sync handshake. Stimulus: FTW_SYNC_WRAP=1, ftw=0x200000 offered mid-period. Response: ftw_ready drops the cycle after transfer; step size stays 0x10 until wrap, becomes 0x20 after it; ftw_ready returns on the wrap edge; a second ftw_valid held high while ready is low is not taken.
- Idle/zero-FTW deadlock avoidance. Stimulus: after reset (ftw_act=0), ftw=0x080000 and sel_req=4 offered with en=0. Response: ftw_act loads and sel=4 on the next edge; phase holds 0x00; wrap stays 0.
- Reset mid-operation and offset. Stimulus: poff=0x40 with running phase, then rst while sel_pending=1 and the shadow is full. Response: phase is offset by +0x40 mod 256; after rst, all outputs are at reset values, ftw_ready=1 and sel_pending=0.
